// File: rtl/elastic_stage_register_pkg.sv
// Shared pipeline constants: control-bundle layout, per-boundary NOP controls,
// stage occupancy encoding and the saturating flush-kill helper.
package elastic_stage_register_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CTRL_W_DEF = 16;
  localparam int unsigned OCC_W      = 2;
  localparam int unsigned KILL_W     = 8;
  localparam int unsigned KILL_SUM_W = KILL_W + 1;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned ALU_OP_W   = 4;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                jump;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_bundle_t;

  localparam logic [OPCODE_W-1:0] NOP_OPCODE = 7'h13;

  // Each pipeline boundary gets its own bubble control value.
  localparam ctrl_bundle_t IF_ID_NOP_CTRL  = '{opcode: NOP_OPCODE, default: '0};
  localparam ctrl_bundle_t ID_EX_NOP_CTRL  = '{opcode: NOP_OPCODE, default: '0};
  localparam ctrl_bundle_t EX_MEM_NOP_CTRL = '{opcode: NOP_OPCODE, default: '0};
  localparam ctrl_bundle_t MEM_WB_NOP_CTRL = '{opcode: NOP_OPCODE, default: '0};

  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

  function automatic logic [KILL_W-1:0] kill_sat_add(input logic [KILL_W-1:0] cnt,
                                                     input logic [OCC_W-1:0]  n);
    logic [KILL_SUM_W-1:0] sum;
    sum = {1'b0, cnt} + KILL_SUM_W'(n);
    return sum[KILL_W] ? {KILL_W{1'b1}} : sum[KILL_W-1:0];
  endfunction

endpackage

// File: rtl/elastic_stage_register_stage_entry.sv
// One held pipeline entry: valid flag plus ctrl/data, reading NOP values when empty.
module stage_entry
  import elastic_stage_register_pkg::*;
#(
  parameter int unsigned       CTRL_W   = CTRL_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter logic [DATA_W-1:0] NOP_DATA = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      valid <= 1'b0;
      ctrl  <= NOP_CTRL;
      data  <= NOP_DATA;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= load_ctrl;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/elastic_stage_register.sv
// Pipeline boundary register: two-entry skid buffer (SKID=1) or single-entry
// register (SKID=0), with flush and a saturating count of flushed entries.
module elastic_stage_register
  import elastic_stage_register_pkg::*;
#(
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       CTRL_W   = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter bit                SKID     = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [KILL_W-1:0] flush_kills
);

  occ_state_e        state_q, state_d;
  logic              in_ready_q;
  logic [KILL_W-1:0] kills_q;

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;
  logic              accept, send;
  logic              main_load, main_clear, main_from_skid, skid_load, skid_clear;

  // Skid mode breaks the out_ready -> in_ready path; register mode keeps it.
  assign in_ready = SKID ? in_ready_q : (!main_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign send     = main_valid && out_ready;

  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_in = main_from_skid ? skid_data : in_data;

  // Next occupancy and entry moves; flush wins over both handshakes.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = OCC_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            state_d   = OCC_ONE;
            main_load = 1'b1;
          end
        end
        OCC_ONE: begin
          if (accept && !send) begin
            state_d   = OCC_FULL;
            skid_load = 1'b1;
          end else if (send && !accept) begin
            state_d    = OCC_EMPTY;
            main_clear = 1'b1;
          end else if (accept && send) begin
            main_load = 1'b1;
          end
        end
        OCC_FULL: begin
          if (send) begin
            state_d        = OCC_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_d    = OCC_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b1;
      kills_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != OCC_FULL);
      if (flush) kills_q <= kill_sat_add(kills_q, OCC_W'(state_q));
    end
  end

  stage_entry #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NOP_CTRL(NOP_CTRL), .NOP_DATA(NOP_DATA)
  ) u_main (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (main_clear),
    .load     (main_load),
    .load_ctrl(main_ctrl_in),
    .load_data(main_data_in),
    .valid    (main_valid),
    .ctrl     (main_ctrl),
    .data     (main_data)
  );

  if (SKID) begin : g_skid
    stage_entry #(
      .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NOP_CTRL(NOP_CTRL), .NOP_DATA(NOP_DATA)
    ) u_skid (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (skid_clear),
      .load     (skid_load),
      .load_ctrl(in_ctrl),
      .load_data(in_data),
      .valid    (skid_valid),
      .ctrl     (skid_ctrl),
      .data     (skid_data)
    );
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_ctrl  = NOP_CTRL;
    assign skid_data  = NOP_DATA;
  end

  assign out_valid   = main_valid;
  assign out_ctrl    = main_ctrl;
  assign out_data    = main_data;
  assign occupancy   = OCC_W'(main_valid) + OCC_W'(skid_valid);
  assign flush_kills = kills_q;

endmodule

// File: tb/tb_elastic_stage_register.sv
// Directed bench for both stage modes; a monitor pops expected beats from per-DUT queues.
module tb_elastic_stage_register;

  localparam logic [15:0] A_NOP_CTRL = 16'h0260;
  localparam logic [63:0] A_NOP_DATA = 64'h0000_0000_0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_ctrl, a_out_ctrl;
  logic [63:0] a_in_data, a_out_data;
  logic [1:0]  a_occupancy;
  logic [7:0]  a_flush_kills;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_ctrl, b_out_ctrl;
  logic [63:0] b_in_data, b_out_data;
  logic [1:0]  b_occupancy;
  logic [7:0]  b_flush_kills;

  elastic_stage_register #(
    .DATA_W(64), .CTRL_W(16), .NOP_CTRL(A_NOP_CTRL), .NOP_DATA(A_NOP_DATA), .SKID(1'b1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occupancy), .flush_kills(a_flush_kills)
  );

  elastic_stage_register #(
    .DATA_W(64), .CTRL_W(16), .SKID(1'b0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occupancy), .flush_kills(b_flush_kills)
  );

  int checks = 0;
  int errors = 0;
  logic [79:0] q_a[$];
  logic [79:0] q_b[$];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ctrl_of(input logic [31:0] x);
    return x[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [63:0] data_of(input logic [31:0] x);
    return {32'hCAFE_0000, x};
  endfunction

  function automatic logic [79:0] beat_of(input logic [31:0] x);
    return {ctrl_of(x), data_of(x)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input logic iv, input logic [31:0] x, input logic ordy, input logic fl);
    a_in_valid  = iv;
    a_in_ctrl   = iv ? ctrl_of(x) : 16'h0;
    a_in_data   = iv ? data_of(x) : 64'h0;
    a_out_ready = ordy;
    a_flush     = fl;
  endtask

  task automatic b_set(input logic iv, input logic [31:0] x, input logic ordy, input logic fl);
    b_in_valid  = iv;
    b_in_ctrl   = iv ? ctrl_of(x) : 16'h0;
    b_in_data   = iv ? data_of(x) : 64'h0;
    b_out_ready = ordy;
    b_flush     = fl;
  endtask

  // Monitor: every delivered beat must match the head of its queue; bubbles show NOP.
  initial begin
    logic [79:0] e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (!a_flush && a_out_valid && a_out_ready) begin
          if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_beat: got %0h expected none", {a_out_ctrl, a_out_data});
          end else begin
            e = q_a.pop_front();
            chk("a_beat", {a_out_ctrl, a_out_data}, e);
          end
        end
        if (!a_out_valid) chk("a_nop", {a_out_ctrl, a_out_data}, {A_NOP_CTRL, A_NOP_DATA});
        if (!b_flush && b_out_valid && b_out_ready) begin
          if (q_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_beat: got %0h expected none", {b_out_ctrl, b_out_data});
          end else begin
            e = q_b.pop_front();
            chk("b_beat", {b_out_ctrl, b_out_data}, e);
          end
        end
        if (!b_out_valid) chk("b_nop", {b_out_ctrl, b_out_data}, 80'h0);
        chk("b_occ_le_1", 80'(b_occupancy > 2'd1), 80'h0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    a_set(1'b0, 0, 1'b0, 1'b0);
    b_set(1'b0, 0, 1'b0, 1'b0);
    tick; tick;

    // Reset state
    chk("rst_a_occ",   80'(a_occupancy), 80'h0);
    chk("rst_a_valid", 80'(a_out_valid), 80'h0);
    chk("rst_a_nop",   {a_out_ctrl, a_out_data}, {A_NOP_CTRL, A_NOP_DATA});
    chk("rst_a_kills", 80'(a_flush_kills), 80'h0);
    chk("rst_b_occ",   80'(b_occupancy), 80'h0);
    reset_n = 1'b1;
    tick;
    chk("rst_a_in_ready", 80'(a_in_ready), 80'h1);
    chk("rst_b_in_ready", 80'(b_in_ready), 80'h1);

    // Four back-to-back beats, stage never holds more than one
    for (int i = 1; i <= 4; i++) begin
      a_set(1'b1, 32'(i), 1'b1, 1'b0);
      q_a.push_back(beat_of(32'(i)));
      tick;
      chk("b2b_occ",   80'(a_occupancy), 80'h1);
      chk("b2b_valid", 80'(a_out_valid), 80'h1);
    end
    a_set(1'b0, 0, 1'b1, 1'b0);
    tick;
    chk("b2b_drain_occ", 80'(a_occupancy), 80'h0);

    // Stall fills main then skid; blocked beat is not sampled
    a_set(1'b1, 32'hA, 1'b0, 1'b0);
    q_a.push_back(beat_of(32'hA));
    tick;
    chk("stall_one_ready", 80'(a_in_ready), 80'h1);
    a_set(1'b1, 32'hB, 1'b0, 1'b0);
    q_a.push_back(beat_of(32'hB));
    tick;
    chk("stall_full_occ",   80'(a_occupancy), 80'h2);
    chk("stall_full_ready", 80'(a_in_ready), 80'h0);
    a_set(1'b1, 32'hC, 1'b0, 1'b0);
    tick;
    chk("stall_hold_occ",  80'(a_occupancy), 80'h2);
    chk("stall_hold_data", 80'(a_out_data), 80'(data_of(32'hA)));
    a_set(1'b0, 0, 1'b1, 1'b0);
    tick;
    chk("release_occ",   80'(a_occupancy), 80'h1);
    chk("release_ready", 80'(a_in_ready), 80'h1);
    tick;
    chk("release_empty", 80'(a_occupancy), 80'h0);

    // Reset with two entries held, together with flush
    a_set(1'b1, 32'h31, 1'b0, 1'b0);
    q_a.push_back(beat_of(32'h31));
    tick;
    a_set(1'b1, 32'h32, 1'b0, 1'b0);
    q_a.push_back(beat_of(32'h32));
    tick;
    chk("prerst_occ", 80'(a_occupancy), 80'h2);
    reset_n = 1'b0;
    a_set(1'b1, 32'h33, 1'b1, 1'b1);
    q_a.delete();
    tick;
    chk("midrst_occ",   80'(a_occupancy), 80'h0);
    chk("midrst_valid", 80'(a_out_valid), 80'h0);
    chk("midrst_nop",   {a_out_ctrl, a_out_data}, {A_NOP_CTRL, A_NOP_DATA});
    chk("midrst_kills", 80'(a_flush_kills), 80'h0);
    reset_n = 1'b1;
    a_set(1'b0, 0, 1'b0, 1'b0);
    tick;
    chk("postrst_ready", 80'(a_in_ready), 80'h1);

    // Flush of a full stage with a beat offered and a send attempted
    a_set(1'b1, 32'h11, 1'b0, 1'b0);
    q_a.push_back(beat_of(32'h11));
    tick;
    a_set(1'b1, 32'h12, 1'b0, 1'b0);
    q_a.push_back(beat_of(32'h12));
    tick;
    a_set(1'b1, 32'h13, 1'b1, 1'b1);
    q_a.delete();
    tick;
    chk("flush_valid", 80'(a_out_valid), 80'h0);
    chk("flush_ctrl",  80'(a_out_ctrl), 80'(A_NOP_CTRL));
    chk("flush_occ",   80'(a_occupancy), 80'h0);
    chk("flush_kills", 80'(a_flush_kills), 80'h2);
    chk("flush_ready", 80'(a_in_ready), 80'h1);
    a_set(1'b0, 0, 1'b1, 1'b0);
    tick; tick;
    chk("flush_no_ghost", 80'(a_out_valid), 80'h0);

    // Saturation of flush_kills
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    a_set(1'b0, 0, 1'b0, 1'b1);
    tick;
    chk("sat_empty_flush", 80'(a_flush_kills), 80'h0);
    for (int n = 0; n < 254; n++) begin
      a_set(1'b1, 32'h100 + 32'(n), 1'b0, 1'b0);
      q_a.push_back(beat_of(32'h100 + 32'(n)));
      tick;
      a_set(1'b0, 0, 1'b0, 1'b1);
      q_a.delete();
      tick;
      if (n == 0) chk("sat_first", 80'(a_flush_kills), 80'h1);
    end
    chk("sat_254", 80'(a_flush_kills), 80'd254);
    a_set(1'b1, 32'h41, 1'b0, 1'b0);
    q_a.push_back(beat_of(32'h41));
    tick;
    a_set(1'b1, 32'h42, 1'b0, 1'b0);
    q_a.push_back(beat_of(32'h42));
    tick;
    a_set(1'b0, 0, 1'b0, 1'b1);
    q_a.delete();
    tick;
    chk("sat_255", 80'(a_flush_kills), 80'd255);
    a_set(1'b1, 32'h43, 1'b0, 1'b0);
    q_a.push_back(beat_of(32'h43));
    tick;
    a_set(1'b0, 0, 1'b0, 1'b1);
    q_a.delete();
    tick;
    chk("sat_hold", 80'(a_flush_kills), 80'd255);
    a_set(1'b0, 0, 1'b0, 1'b0);
    tick;

    // Single-entry mode: in_ready follows out_ready combinationally
    b_set(1'b1, 32'h21, 1'b1, 1'b0);
    #1 chk("reg_rdy_empty", 80'(b_in_ready), 80'h1);
    q_b.push_back(beat_of(32'h21));
    tick;
    chk("reg_occ1", 80'(b_occupancy), 80'h1);
    b_set(1'b1, 32'h22, 1'b0, 1'b0);
    #1 chk("reg_rdy_stall", 80'(b_in_ready), 80'h0);
    tick;
    chk("reg_hold_data", 80'(b_out_data), 80'(data_of(32'h21)));
    b_set(1'b1, 32'h22, 1'b1, 1'b0);
    #1 chk("reg_rdy_go", 80'(b_in_ready), 80'h1);
    q_b.push_back(beat_of(32'h22));
    tick;
    chk("reg_swap_occ",  80'(b_occupancy), 80'h1);
    chk("reg_swap_data", 80'(b_out_data), 80'(data_of(32'h22)));
    b_set(1'b0, 0, 1'b0, 1'b0);
    #1 chk("reg_rdy_full_stall", 80'(b_in_ready), 80'h0);
    tick;
    b_set(1'b0, 0, 1'b1, 1'b0);
    #1 chk("reg_rdy_full_go", 80'(b_in_ready), 80'h1);
    tick;
    chk("reg_drain_occ", 80'(b_occupancy), 80'h0);
    b_set(1'b0, 0, 1'b0, 1'b0);
    #1 chk("reg_rdy_idle", 80'(b_in_ready), 80'h1);

    for (int i = 0; i < 3; i++) begin
      b_set(1'b1, 32'h50 + 32'(i), 1'b1, 1'b0);
      q_b.push_back(beat_of(32'h50 + 32'(i)));
      tick;
      chk("reg_b2b_occ", 80'(b_occupancy), 80'h1);
    end
    b_set(1'b0, 0, 1'b1, 1'b0);
    tick;

    b_set(1'b1, 32'h60, 1'b0, 1'b0);
    q_b.push_back(beat_of(32'h60));
    tick;
    b_set(1'b0, 0, 1'b0, 1'b1);
    q_b.delete();
    tick;
    chk("reg_flush_kills", 80'(b_flush_kills), 80'h1);
    chk("reg_flush_valid", 80'(b_out_valid), 80'h0);
    b_set(1'b0, 0, 1'b0, 1'b0);
    tick; tick;

    chk("a_queue_empty", 80'(q_a.size()), 80'h0);
    chk("b_queue_empty", 80'(q_b.size()), 80'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
